// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: captures the execute bundle, runs one request/ack
// data-memory access at a time with a timeout, and presents a registered writeback bundle.
// Optional build macro: MEM_MISALIGN_CHECK_EN (misaligned loads/stores bypass memory, flag misalign).
module mem_access_stage #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_ready,
  input  logic [31:0] ac_pc,
  input  logic [4:0]  ac_write_sel,
  input  logic        ac_is_load,
  input  logic        ac_is_store,
  input  logic        ac_is_wb,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ac_store_data,
  output logic        c_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        w_ready,
  output logic        cw_valid,
  output logic [31:0] cw_pc,
  output logic [4:0]  cw_write_sel,
  output logic        cw_is_wb,
  output logic [31:0] cw_data,
  output logic        mem_err,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        dbg_state
);

  // Handshakes: execute->here transfers on an edge with a_ready && c_ready; here->writeback
  // transfers on an edge with cw_valid && w_ready; dmem completes on an edge with dmem_req && dmem_ack.
  typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]        op_pc_q, op_pc_d;
  logic [4:0]         op_sel_q, op_sel_d;
  logic               op_wb_q, op_wb_d;
  logic               cw_valid_q, cw_valid_d, cw_wb_q, cw_wb_d;
  logic [31:0]        cw_pc_q, cw_pc_d, cw_data_q, cw_data_d;
  logic [4:0]         cw_sel_q, cw_sel_d;
  logic               err_q, err_d, mis_q, mis_d;
  logic               capture, is_mem, misaligned;

  assign c_ready = (state_q == S_IDLE) && (!cw_valid_q || w_ready);
  assign capture = c_ready && a_ready;
  assign is_mem  = ac_is_load || ac_is_store;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = is_mem && (ALU_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_pc_d    = op_pc_q;
    op_sel_d   = op_sel_q;
    op_wb_d    = op_wb_q;
    cw_valid_d = cw_valid_q;
    cw_pc_d    = cw_pc_q;
    cw_sel_d   = cw_sel_q;
    cw_wb_d    = cw_wb_q;
    cw_data_d  = cw_data_q;
    err_d      = err_q;
    mis_d      = mis_q;
    if (cw_valid_q && w_ready) begin
      cw_valid_d = 1'b0;
      mis_d      = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (capture && is_mem && !misaligned) begin
          state_d  = S_MEM;
          req_d    = 1'b1;
          we_d     = ac_is_store;  // load+store together resolves to a store
          addr_d   = {ALU_result[31:2], 2'b00};
          wdata_d  = ac_store_data;
          cnt_d    = '0;
          op_pc_d  = ac_pc;
          op_sel_d = ac_write_sel;
          op_wb_d  = ac_is_wb;
        end else if (capture) begin
          cw_valid_d = 1'b1;
          cw_pc_d    = ac_pc;
          cw_sel_d   = ac_write_sel;
          cw_wb_d    = ac_is_wb && !misaligned;
          cw_data_d  = ALU_result;
          mis_d      = misaligned;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          cw_valid_d = 1'b1;
          cw_pc_d    = op_pc_q;
          cw_sel_d   = op_sel_q;
          cw_wb_d    = we_q ? 1'b0 : op_wb_q;
          cw_data_d  = we_q ? addr_q : dmem_rdata;
          mis_d      = 1'b0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          err_d      = 1'b1;
          cw_valid_d = 1'b1;
          cw_pc_d    = op_pc_q;
          cw_sel_d   = op_sel_q;
          cw_wb_d    = 1'b0;
          cw_data_d  = '0;
          mis_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_pc_q    <= '0;
      op_sel_q   <= '0;
      op_wb_q    <= 1'b0;
      cw_valid_q <= 1'b0;
      cw_pc_q    <= '0;
      cw_sel_q   <= '0;
      cw_wb_q    <= 1'b0;
      cw_data_q  <= '0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_pc_q    <= op_pc_d;
      op_sel_q   <= op_sel_d;
      op_wb_q    <= op_wb_d;
      cw_valid_q <= cw_valid_d;
      cw_pc_q    <= cw_pc_d;
      cw_sel_q   <= cw_sel_d;
      cw_wb_q    <= cw_wb_d;
      cw_data_q  <= cw_data_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign cw_valid     = cw_valid_q;
  assign cw_pc        = cw_pc_q;
  assign cw_write_sel = cw_sel_q;
  assign cw_is_wb     = cw_wb_q;
  assign cw_data      = cw_data_q;
  assign mem_err      = err_q;
  assign dbg_state    = state_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign     = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU ops, load/store, backpressure, timeout, async reset.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_ready = 1'b0;
  logic [31:0] ac_pc = '0;
  logic [4:0]  ac_write_sel = '0;
  logic        ac_is_load = 1'b0, ac_is_store = 1'b0, ac_is_wb = 1'b0;
  logic [31:0] ALU_result = '0, ac_store_data = '0;
  logic        c_ready, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        w_ready = 1'b1;
  logic        cw_valid, cw_is_wb, mem_err, dbg_state;
  logic [31:0] cw_pc, cw_data;
  logic [4:0]  cw_write_sel;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .a_ready(a_ready), .ac_pc(ac_pc),
    .ac_write_sel(ac_write_sel), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
    .ac_is_wb(ac_is_wb), .ALU_result(ALU_result), .ac_store_data(ac_store_data),
    .c_ready(c_ready), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .w_ready(w_ready), .cw_valid(cw_valid), .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
    .cw_is_wb(cw_is_wb), .cw_data(cw_data), .mem_err(mem_err),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [4:0] sel, input logic ld,
                        input logic st, input logic wb, input logic [31:0] alu,
                        input logic [31:0] sd);
    a_ready = 1'b1; ac_pc = pc; ac_write_sel = sel; ac_is_load = ld; ac_is_store = st;
    ac_is_wb = wb; ALU_result = alu; ac_store_data = sd;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL reset_cw_valid: got %b expected 0", cw_valid); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    checks++; if (cw_data !== 32'h0) begin errors++; $display("FAIL reset_cw_data: got %h expected 0", cw_data); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_c_ready: got %b expected 1", c_ready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu_op();
    set_op(32'h40, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0);
    step();
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL alu_cw_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_data !== 32'h1234) begin errors++; $display("FAIL alu_cw_data: got %h expected 00001234", cw_data); end
    checks++; if (cw_is_wb !== 1'b1) begin errors++; $display("FAIL alu_cw_is_wb: got %b expected 1", cw_is_wb); end
    checks++; if (cw_pc !== 32'h40) begin errors++; $display("FAIL alu_cw_pc: got %h expected 00000040", cw_pc); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL alu_c_ready: got %b expected 1", c_ready); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b expected 0", dmem_req); end
  endtask

  task automatic test_back_to_back();
    set_op(32'h44, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0000_5678, 32'h0);
    step();
    checks++; if (cw_data !== 32'h5678) begin errors++; $display("FAIL b2b_cw_data: got %h expected 00005678", cw_data); end
    checks++; if (cw_write_sel !== 5'd4) begin errors++; $display("FAIL b2b_cw_sel: got %0d expected 4", cw_write_sel); end
    checks++; if (cw_is_wb !== 1'b0) begin errors++; $display("FAIL b2b_cw_is_wb: got %b expected 0", cw_is_wb); end
    a_ready = 1'b0;
    step();
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", cw_valid); end
  endtask

  task automatic test_load();
    set_op(32'h80, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    step();
    a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL load_req_c%0d: got %b expected 1", i, dmem_req); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL load_we_c%0d: got %b expected 0", i, dmem_we); end
      checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL load_addr_c%0d: got %h expected 00000100", i, dmem_addr); end
      checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL load_c_ready_c%0d: got %b expected 0", i, c_ready); end
      checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL load_cw_early_c%0d: got %b expected 0", i, cw_valid); end
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
      step();
    end
    dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL load_cw_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_cw_data: got %h expected deadbeef", cw_data); end
    checks++; if (cw_is_wb !== 1'b1) begin errors++; $display("FAIL load_cw_is_wb: got %b expected 1", cw_is_wb); end
    checks++; if (cw_pc !== 32'h80) begin errors++; $display("FAIL load_cw_pc: got %h expected 00000080", cw_pc); end
    checks++; if (cw_write_sel !== 5'd5) begin errors++; $display("FAIL load_cw_sel: got %0d expected 5", cw_write_sel); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b expected 0", dmem_req); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL load_c_ready_after: got %b expected 1", c_ready); end
    step();
  endtask

  task automatic test_store();
    // ack held high at the capture edge is outside S_MEM and must be ignored
    set_op(32'hC0, 5'd6, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h55AA_55AA);
    dmem_ack = 1'b1;
    step();
    a_ready = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL store_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL store_we: got %b expected 1", dmem_we); end
    checks++; if (dmem_addr !== 32'h204) begin errors++; $display("FAIL store_addr: got %h expected 00000204", dmem_addr); end
    checks++; if (dmem_wdata !== 32'h55AA_55AA) begin errors++; $display("FAIL store_wdata: got %h expected 55aa55aa", dmem_wdata); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL store_cw_early: got %b expected 0", cw_valid); end
    step();
    dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL store_cw_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_is_wb !== 1'b0) begin errors++; $display("FAIL store_cw_is_wb: got %b expected 0", cw_is_wb); end
    checks++; if (cw_data !== 32'h204) begin errors++; $display("FAIL store_cw_data: got %h expected 00000204", cw_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL store_req_drop: got %b expected 0", dmem_req); end
    step();
  endtask

  task automatic test_backpressure();
    w_ready = 1'b0;
    set_op(32'h100, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0000_AAAA, 32'h0);
    step();
    set_op(32'h104, 5'd8, 1'b0, 1'b0, 1'b1, 32'h0000_BBBB, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL bp_cw_valid_c%0d: got %b expected 1", i, cw_valid); end
      checks++; if (cw_data !== 32'hAAAA) begin errors++; $display("FAIL bp_cw_data_c%0d: got %h expected 0000aaaa", i, cw_data); end
      checks++; if (cw_write_sel !== 5'd7) begin errors++; $display("FAIL bp_cw_sel_c%0d: got %0d expected 7", i, cw_write_sel); end
      checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL bp_c_ready_c%0d: got %b expected 0", i, c_ready); end
      if (i < 3) step();
    end
    w_ready = 1'b1;
    #1;
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL bp_c_ready_release: got %b expected 1", c_ready); end
    step();
    a_ready = 1'b0;
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL bp_overwrite_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_data !== 32'hBBBB) begin errors++; $display("FAIL bp_overwrite_data: got %h expected 0000bbbb", cw_data); end
    checks++; if (cw_pc !== 32'h104) begin errors++; $display("FAIL bp_overwrite_pc: got %h expected 00000104", cw_pc); end
    step();
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL bp_final_drain: got %b expected 0", cw_valid); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_op(32'h200, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0);
    step();
    a_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!dmem_req) begin n = i; break; end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d expected 16 (0 = never dropped)", n); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b expected 1", mem_err); end
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL timeout_cw_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_is_wb !== 1'b0) begin errors++; $display("FAIL timeout_cw_is_wb: got %b expected 0", cw_is_wb); end
    checks++; if (cw_data !== 32'h0) begin errors++; $display("FAIL timeout_cw_data: got %h expected 0", cw_data); end
    set_op(32'h204, 5'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0);
    step();
    a_ready = 1'b0;
    step();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_err); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_reset_clears: got %b expected 0", mem_err); end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    set_op(32'h300, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
    step();
    a_ready = 1'b0;
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b expected 1", dmem_req); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL areset_req_drop: got %b expected 0", dmem_req); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL areset_cw_valid: got %b expected 0", cw_valid); end
    @(negedge clock);
    reset = 1'b1;
    step();
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL areset_state: got %b expected 0", dbg_state); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL areset_c_ready: got %b expected 1", c_ready); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL areset_no_wb: got %b expected 0", cw_valid); end
  endtask

  task automatic test_low_addr_bits();
`ifdef MEM_MISALIGN_CHECK_EN
    set_op(32'h400, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0);
    step();
    a_ready = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", dmem_req); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign); end
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL mis_cw_valid: got %b expected 1", cw_valid); end
    checks++; if (cw_is_wb !== 1'b0) begin errors++; $display("FAIL mis_cw_is_wb: got %b expected 0", cw_is_wb); end
    checks++; if (cw_data !== 32'h102) begin errors++; $display("FAIL mis_cw_data: got %h expected 00000102", cw_data); end
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign); end
`else
    set_op(32'h400, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h0);
    step();
    a_ready = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lowbits_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL lowbits_addr: got %h expected 00000100", dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    step();
    dmem_ack = 1'b0;
    checks++; if (cw_data !== 32'h1357_9BDF) begin errors++; $display("FAIL lowbits_cw_data: got %h expected 13579bdf", cw_data); end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load();
    test_store();
    test_backpressure();
    test_timeout();
    test_async_reset();
    test_low_addr_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
